output_accum: RTL and testbench
===============================

OUTPUT_ACCUM -- requirements
Module: output_accum

Interface
REQ-001 Parameter PROD_W, default 16: signed product width.
REQ-002 Parameter ACC_W, default 21: signed accumulator width (PROD_W+5, so 24 worst-case products cannot overflow).
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  begin a new frame; sampled only in IDLE.
REQ-006 num_pairs  input  5  number of (coordinate, product) pairs in the frame, 0..24; sampled with start.
REQ-007 in_valid  input  1  input pair valid.
REQ-008 in_ready  output  1  block accepts a pair this cycle.
REQ-009 in_cord  input  4  output-tile coordinate, 0..15, from the output coordinate stage.
REQ-010 in_cord_ok  input  1  1 = coordinate inside tile; 0 = out-of-tile product, counted but discarded.
REQ-011 in_prod  input  PROD_W  signed weight*activation product.
REQ-012 out_valid  output  1  drain word valid.
REQ-013 out_ready  input  1  downstream accepts the drain word.
REQ-014 out_addr  output  4  coordinate of the drain word.
REQ-015 out_data  output  ACC_W  accumulated sum for out_addr.
REQ-016 out_last  output  1  high with the word at out_addr 15.
REQ-017 busy  output  1  high in any state other than IDLE.

Function
REQ-018 The block SHALL hold 16 signed ACC_W accumulators indexed by coordinate, plus a 5-bit remaining-pair counter.
REQ-019 The FSM SHALL have states IDLE, ACCUM and DRAIN.
REQ-020 IDLE: start=1 with num_pairs>0 SHALL clear all 16 accumulators, load the counter with num_pairs and enter ACCUM next cycle.
REQ-021 IDLE: start=1 with num_pairs=0 SHALL clear the accumulators and enter DRAIN directly, draining 16 zeros.
REQ-022 start SHALL be ignored in ACCUM and DRAIN.
REQ-023 in_ready SHALL be 1 exactly when the state is ACCUM.
REQ-024 A transfer SHALL occur when in_valid and in_ready are both 1; each transfer decrements the counter by 1.
REQ-025 On a transfer with in_cord_ok=1, acc[in_cord] SHALL become acc[in_cord] + sign-extended in_prod, visible to the next transfer.
REQ-026 Back-to-back transfers to the same coordinate SHALL sum correctly with no stall.
REQ-027 On a transfer with in_cord_ok=0, the accumulators SHALL be unchanged; the counter still decrements.
REQ-028 The transfer that brings the counter to 0 SHALL move the FSM to DRAIN on the next cycle; no further in_ready.
REQ-029 DRAIN: out_valid SHALL be 1, with out_addr starting at 0 and out_data = acc[out_addr].
REQ-030 out_addr SHALL advance by 1 only when out_valid and out_ready are both 1.
REQ-031 out_addr, out_data and out_last SHALL stay stable while out_valid=1 and out_ready=0.
REQ-032 The handshake at out_addr 15 SHALL return the FSM to IDLE on the next cycle; out_valid then drops to 0.
REQ-033 Latency: in_ready SHALL rise 1 cycle after start is sampled; out_valid SHALL rise 1 cycle after the final input transfer.
REQ-034 Minimum frame length SHALL be 1 + num_pairs + 16 cycles with in_valid and out_ready held at 1.

Reset
REQ-035 While rst_n=0 at a clock edge, the block SHALL enter IDLE, zero all accumulators, counter and out_addr, and drive in_ready, out_valid, out_last and busy to 0.
REQ-036 Reset mid-ACCUM or mid-DRAIN SHALL abandon the frame; no partial drain words follow reset release.
REQ-037 The first start SHALL be accepted on the first edge after rst_n returns to 1.

Verification
REQ-038 start, num_pairs=3; pairs (5,+10),(5,-3),(9,+7), all ok -> drain acc[5]=7, acc[9]=7, others 0; out_last only at addr 15.
REQ-039 num_pairs=24, all to cord 0, prod=-32768 -> acc[0]=-786432, no wrap.
REQ-040 num_pairs=2: (3,+4) ok=1, (3,+100) ok=0 -> acc[3]=4; in_ready drops after the 2nd transfer.
REQ-041 out_ready toggled 1/0 every cycle in DRAIN -> 16 words in order 0..15, outputs stable on stall cycles, DRAIN takes 32 cycles.
REQ-042 num_pairs=0 -> DRAIN of 16 zeros; start pulsed during DRAIN -> ignored.
REQ-043 rst_n=0 after 2 of 4 pairs, then new frame with 1 pair (2,+1) -> only acc[2]=1 in the drain.

Source files
------------

// File: rtl/output_accum.sv
// Output accumulator: gathers signed products into 16 per-coordinate
// accumulators over a frame, then drains all 16 sums in coordinate order.
module output_accum #(
  parameter int PROD_W = 16,
  parameter int ACC_W  = 21
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [4:0]               num_pairs,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_cord,
  input  logic                     in_cord_ok,
  input  logic signed [PROD_W-1:0] in_prod,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [3:0]               out_addr,
  output logic signed [ACC_W-1:0]  out_data,
  output logic                     out_last,
  output logic                     busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                  state;
  logic [4:0]              remaining;
  logic signed [ACC_W-1:0] acc [16];
  logic signed [ACC_W-1:0] prod_ext;

  // Sign-extend the incoming product to accumulator width.
  always_comb begin
    prod_ext = {{(ACC_W-PROD_W){in_prod[PROD_W-1]}}, in_prod};
  end

  // Drain word is a direct read of the accumulator at the current address,
  // so it stays stable for as long as the address is held.
  always_comb begin
    out_data = acc[out_addr];
  end

  // Frame control FSM; handshake flags are registered alongside the state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      remaining <= 5'd0;
      out_addr  <= 4'd0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        acc[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < 16; i++) begin
              acc[i] <= '0;
            end
            out_addr <= 4'd0;
            out_last <= 1'b0;
            busy     <= 1'b1;
            if (num_pairs != 5'd0) begin
              remaining <= num_pairs;
              in_ready  <= 1'b1;
              state     <= ACCUM;
            end else begin
              remaining <= 5'd0;
              out_valid <= 1'b1;
              state     <= DRAIN;
            end
          end
        end

        ACCUM: begin
          if (in_valid) begin
            if (in_cord_ok) begin
              acc[in_cord] <= acc[in_cord] + prod_ext;
            end
            remaining <= remaining - 5'd1;
            if (remaining == 5'd1) begin
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              out_last  <= 1'b0;
              state     <= DRAIN;
            end
          end
        end

        DRAIN: begin
          if (out_ready) begin
            if (out_addr == 4'd15) begin
              out_addr  <= 4'd0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              busy      <= 1'b0;
              state     <= IDLE;
            end else begin
              out_addr <= out_addr + 4'd1;
              out_last <= (out_addr == 4'd14);
            end
          end
        end

        default: begin
          state     <= IDLE;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_output_accum.sv
// Testbench for output_accum: random and directed frames, expected drain
// words queued by a reference model and checked by an independent monitor.
module tb_output_accum;

  localparam int PROD_W = 16;
  localparam int ACC_W  = 21;

  logic                     clk;
  logic                     rst_n;
  logic                     start;
  logic [4:0]               num_pairs;
  logic                     in_valid;
  logic                     in_ready;
  logic [3:0]               in_cord;
  logic                     in_cord_ok;
  logic signed [PROD_W-1:0] in_prod;
  logic                     out_valid;
  logic                     out_ready;
  logic [3:0]               out_addr;
  logic signed [ACC_W-1:0]  out_data;
  logic                     out_last;
  logic                     busy;

  typedef struct {
    int addr;
    int data;
    int last;
  } exp_t;

  exp_t sb[$];

  int compared   = 0;
  int mismatched = 0;
  int ready_mode = 0;

  int          f_cord [24];
  int          f_ok   [24];
  int          f_prod [24];

  output_accum #(.PROD_W(PROD_W), .ACC_W(ACC_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .num_pairs  (num_pairs),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_cord    (in_cord),
    .in_cord_ok (in_cord_ok),
    .in_prod    (in_prod),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_addr   (out_addr),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Downstream ready pattern: 0 = always ready, 1 = alternate starting
  // with a stall on the first drain cycle, 2 = random.
  initial begin
    bit tog;
    out_ready = 1'b1;
    tog = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: begin
          if (!out_valid) begin
            tog = 1'b0;
            out_ready = 1'b0;
          end else begin
            out_ready = tog;
            tog = ~tog;
          end
        end
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: pops the scoreboard on every drain handshake and checks that
  // a stalled word is held unchanged into the following cycle.
  initial begin
    bit have_prev;
    int p_addr, p_data, p_last;
    exp_t e;
    have_prev = 1'b0;
    p_addr = 0;
    p_data = 0;
    p_last = 0;
    forever begin
      @(negedge clk);
      if (!rst_n || !out_valid) begin
        have_prev = 1'b0;
      end else begin
        if (have_prev) begin
          checkOutput("stall_addr", int'(out_addr), p_addr);
          checkOutput("stall_data", int'(out_data), p_data);
          checkOutput("stall_last", int'(out_last), p_last);
        end
        if (out_ready) begin
          have_prev = 1'b0;
          if (sb.size() == 0) begin
            checkOutput("unexpected_word_addr", int'(out_addr), -1);
          end else begin
            e = sb.pop_front();
            checkOutput("drain_addr", int'(out_addr), e.addr);
            checkOutput("drain_data", int'(out_data), e.data);
            checkOutput("drain_last", int'(out_last), e.last);
          end
        end else begin
          have_prev = 1'b1;
          p_addr = int'(out_addr);
          p_data = int'(out_data);
          p_last = int'(out_last);
        end
      end
    end
  end

  // Runs one frame of n pairs from f_*; the reference sums are pushed to the
  // scoreboard up front. valid_pct sets in_valid density, start_in_drain
  // pulses start mid-drain, which must be ignored.
  task automatic applyStimulus(input int n, input int valid_pct, input int mode,
                               input bit start_in_drain);
    int exp_acc [16];
    int i, guard, dc;
    bit rdy;
    time t0, t1;
    exp_t e;

    ready_mode = mode;
    for (int k = 0; k < 16; k++) exp_acc[k] = 0;
    for (int k = 0; k < n; k++) begin
      if (f_ok[k] != 0) exp_acc[f_cord[k]] += f_prod[k];
    end
    for (int k = 0; k < 16; k++) begin
      e.addr = k;
      e.data = exp_acc[k];
      e.last = (k == 15) ? 1 : 0;
      sb.push_back(e);
    end

    start = 1'b1;
    num_pairs = 5'(n);
    @(posedge clk);
    #1;
    start = 1'b0;
    t0 = $time;
    if (n > 0) checkOutput("in_ready_after_start", int'(in_ready), 1);
    else checkOutput("out_valid_after_zero_start", int'(out_valid), 1);

    i = 0;
    guard = 0;
    while (i < n && guard < 1000) begin
      in_valid   = ($urandom_range(0, 99) < valid_pct) ? 1'b1 : 1'b0;
      in_cord    = 4'(f_cord[i]);
      in_cord_ok = (f_ok[i] != 0) ? 1'b1 : 1'b0;
      in_prod    = PROD_W'(f_prod[i]);
      rdy = in_ready;
      @(posedge clk);
      #1;
      if (in_valid && rdy) i++;
      guard++;
    end
    in_valid = 1'b0;
    if (guard >= 1000) checkOutput("accum_timeout", 1, 0);
    checkOutput("in_ready_after_last", int'(in_ready), 0);
    checkOutput("out_valid_after_last", int'(out_valid), 1);

    dc = 0;
    guard = 0;
    while (busy && guard < 1000) begin
      if (out_valid) dc++;
      start = (start_in_drain && dc == 3) ? 1'b1 : 1'b0;
      num_pairs = 5'd5;
      @(posedge clk);
      #1;
      guard++;
    end
    start = 1'b0;
    t1 = $time;
    if (guard >= 1000) checkOutput("drain_timeout", 1, 0);
    if (mode == 0) checkOutput("drain_cycles", dc, 16);
    if (mode == 1) checkOutput("drain_cycles_toggle", dc, 32);
    if (mode == 0 && valid_pct >= 100)
      checkOutput("frame_busy_cycles", int'((t1 - t0) / 10), n + 16);
    checkOutput("out_valid_idle", int'(out_valid), 0);
    @(posedge clk);
    #1;
    checkOutput("busy_stays_idle", int'(busy), 0);
    checkOutput("sb_drained", sb.size(), 0);
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    num_pairs  = 5'd0;
    in_valid   = 1'b0;
    in_cord    = 4'd0;
    in_cord_ok = 1'b0;
    in_prod    = '0;
    for (int k = 0; k < 24; k++) begin
      f_cord[k] = 0;
      f_ok[k]   = 0;
      f_prod[k] = 0;
    end

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_in_ready", int'(in_ready), 0);
    checkOutput("reset_out_valid", int'(out_valid), 0);
    checkOutput("reset_out_last", int'(out_last), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_out_addr", int'(out_addr), 0);
    rst_n = 1'b1;

    $display("[TB] directed frame: three pairs");
    f_cord[0] = 5; f_ok[0] = 1; f_prod[0] = 10;
    f_cord[1] = 5; f_ok[1] = 1; f_prod[1] = -3;
    f_cord[2] = 9; f_ok[2] = 1; f_prod[2] = 7;
    applyStimulus(3, 100, 0, 1'b0);

    $display("[TB] directed frame: 24 max-negative products");
    for (int k = 0; k < 24; k++) begin
      f_cord[k] = 0; f_ok[k] = 1; f_prod[k] = -32768;
    end
    applyStimulus(24, 100, 0, 1'b0);

    $display("[TB] directed frame: out-of-tile discard");
    f_cord[0] = 3; f_ok[0] = 1; f_prod[0] = 4;
    f_cord[1] = 3; f_ok[1] = 0; f_prod[1] = 100;
    applyStimulus(2, 100, 0, 1'b0);

    $display("[TB] toggled out_ready during drain");
    for (int k = 0; k < 8; k++) begin
      f_cord[k] = $urandom_range(0, 15);
      f_ok[k]   = 1;
      f_prod[k] = $urandom_range(0, 65535) - 32768;
    end
    applyStimulus(8, 100, 1, 1'b0);

    $display("[TB] empty frame with start pulsed in drain");
    applyStimulus(0, 100, 0, 1'b1);

    $display("[TB] reset mid-accumulate");
    start = 1'b1;
    num_pairs = 5'd4;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1;
      in_cord = 4'd7;
      in_cord_ok = 1'b1;
      in_prod = 16'sd50;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("abort_in_ready", int'(in_ready), 0);
    checkOutput("abort_out_valid", int'(out_valid), 0);
    checkOutput("abort_busy", int'(busy), 0);
    rst_n = 1'b1;
    f_cord[0] = 2; f_ok[0] = 1; f_prod[0] = 1;
    applyStimulus(1, 100, 0, 1'b0);

    $display("[TB] random frames");
    for (int fr = 0; fr < 12; fr++) begin
      int n;
      n = $urandom_range(1, 24);
      for (int k = 0; k < n; k++) begin
        f_cord[k] = $urandom_range(0, 15);
        f_ok[k]   = ($urandom_range(0, 3) != 0) ? 1 : 0;
        f_prod[k] = $urandom_range(0, 65535) - 32768;
      end
      applyStimulus(n, (fr < 4) ? 100 : 65, (fr < 4) ? 0 : 2, 1'b0);
    end

    repeat (4) @(posedge clk);
    #1;
    checkOutput("final_sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
